// File: rtl/sdf_r2_stage.sv
// rtl/sdf_r2_stage.sv - radix-2 single-path delay-feedback FFT butterfly stage
// Pairs each sample with the one DEPTH accepts earlier; sums leave directly, differences recirculate.
module sdf_r2_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic             out_first,
  output logic             out_diff
);

  localparam int CW = $clog2(2 * DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * DEPTH - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DEPTH);

  logic [CW-1:0]    cnt;
  logic             primed;
  logic [WIDTH-1:0] dl_re [DEPTH];
  logic [WIDTH-1:0] dl_im [DEPTH];

  logic             phase;
  logic [WIDTH-1:0] head_re, head_im;
  logic [WIDTH-1:0] sum_re, sum_im, dif_re, dif_im;
  logic [WIDTH-1:0] push_re, push_im;

  // Keep WIDTH+1 bits of the exact result, then drop bit WIDTH-1: the low bits
  // are kept and the MSB is replaced by the extended sign bit, without saturation.
  function automatic logic [WIDTH-1:0] drop_guard(input logic [WIDTH:0] r);
    return r[WIDTH-1:0] ^ {r[WIDTH] ^ r[WIDTH-1], {(WIDTH-1){1'b0}}};
  endfunction

  function automatic logic [WIDTH-1:0] add_c(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return drop_guard({a[WIDTH-1], a} + {b[WIDTH-1], b});
  endfunction

  function automatic logic [WIDTH-1:0] sub_c(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return drop_guard({a[WIDTH-1], a} - {b[WIDTH-1], b});
  endfunction

  always_comb begin
    phase   = cnt[CW-1];
    head_re = dl_re[DEPTH-1];
    head_im = dl_im[DEPTH-1];
    sum_re  = add_c(head_re, in_re);
    sum_im  = add_c(head_im, in_im);
    dif_re  = sub_c(head_re, in_re);
    dif_im  = sub_c(head_im, in_im);
    push_re = phase ? dif_re : in_re;
    push_im = phase ? dif_im : in_im;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_diff  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dl_re[i] <= '0;
        dl_im[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_diff  <= 1'b0;
      if (in_valid) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_LAST)
          primed <= 1'b1;
        for (int i = DEPTH - 1; i > 0; i--) begin
          dl_re[i] <= dl_re[i-1];
          dl_im[i] <= dl_im[i-1];
        end
        dl_re[0] <= push_re;
        dl_im[0] <= push_im;
        if (phase) begin
          out_valid <= 1'b1;
          out_re    <= sum_re;
          out_im    <= sum_im;
          out_first <= (cnt == CNT_HALF);
        end else begin
          // Fill phase: the head holds last frame's difference, valid only once primed.
          out_valid <= primed;
          out_diff  <= primed;
          out_re    <= head_re;
          out_im    <= head_im;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdf_r2_stage.sv
// tb/tb_sdf_r2_stage.sv - self-checking bench for sdf_r2_stage
// Reference model pairs samples by frame position from the full accepted-sample history.
module tb_sdf_r2_stage;

  localparam int D = 32;
  localparam int F = 2 * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_re = '0, in_im = '0;
  logic        out_valid, out_first, out_diff;
  logic [15:0] out_re, out_im;

  logic        in_valid1 = 1'b0;
  logic [15:0] in_re1 = '0, in_im1 = '0;
  logic        out_valid1, out_first1, out_diff1;
  logic [15:0] out_re1, out_im1;

  int checks = 0;
  int failures = 0;
  int hist_re[$];
  int hist_im[$];

  always #5 clk = ~clk;

  sdf_r2_stage #(.WIDTH(16), .DEPTH(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
    .out_first(out_first), .out_diff(out_diff)
  );

  sdf_r2_stage #(.WIDTH(16), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_re(in_re1), .in_im(in_im1),
    .out_valid(out_valid1), .out_re(out_re1), .out_im(out_im1),
    .out_first(out_first1), .out_diff(out_diff1)
  );

  function automatic logic [15:0] wrapf(input int s);
    logic [16:0] t;
    t = s[16:0];
    return {t[16], t[14:0]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [15:0] re, input logic [15:0] im);
    int n, pos, fr, base;
    logic ev, ef, ed;
    logic [15:0] er, ei;
    @(negedge clk);
    in_valid = v; in_re = re; in_im = im;
    ev = 1'b0; ef = 1'b0; ed = 1'b0; er = '0; ei = '0;
    if (v) begin
      n = hist_re.size();
      pos = n % F;
      fr = n / F;
      hist_re.push_back(int'($signed(re)));
      hist_im.push_back(int'($signed(im)));
      base = fr * F;
      if (pos >= D) begin
        ev = 1'b1; ef = (pos == D);
        er = wrapf(hist_re[base + pos - D] + hist_re[n]);
        ei = wrapf(hist_im[base + pos - D] + hist_im[n]);
      end else if (fr >= 1) begin
        ev = 1'b1; ed = 1'b1;
        er = wrapf(hist_re[base - F + pos] - hist_re[base - F + D + pos]);
        ei = wrapf(hist_im[base - F + pos] - hist_im[base - F + D + pos]);
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 16'(out_valid), 16'(ev));
    if (ev) begin
      chk("out_re", out_re, er);
      chk("out_im", out_im, ei);
      chk("out_first", 16'(out_first), 16'(ef));
      chk("out_diff", 16'(out_diff), 16'(ed));
    end
  endtask

  task automatic step1(input logic [15:0] re, input bit ev, input logic [15:0] er,
                       input bit ef, input bit ed);
    @(negedge clk);
    in_valid1 = 1'b1; in_re1 = re; in_im1 = '0;
    @(posedge clk);
    #1;
    chk("d1_out_valid", 16'(out_valid1), 16'(ev));
    if (ev) begin
      chk("d1_out_re", out_re1, er);
      chk("d1_out_im", out_im1, 16'h0000);
      chk("d1_out_first", 16'(out_first1), 16'(ef));
      chk("d1_out_diff", 16'(out_diff1), 16'(ed));
    end
    @(negedge clk);
    in_valid1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_out_first", 16'(out_first), 16'h0);
    chk("rst_out_diff", 16'(out_diff), 16'h0);
    chk("rst_out_re", out_re, 16'h0);
    chk("rst_out_im", out_im, 16'h0);
    hist_re.delete();
    hist_im.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic const_frame(input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) step(1'b1, v, 16'h0000);
  endtask

  initial begin
    logic [15:0] r, q;
    repeat (2) @(negedge clk);
    do_reset();

    // DEPTH=1 wrap-around cases
    step1(16'h7FFF, 1'b0, 16'h0000, 1'b0, 1'b0);
    step1(16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0);
    step1(16'h8000, 1'b1, 16'h7FFE, 1'b0, 1'b1);
    step1(16'h8000, 1'b1, 16'h8000, 1'b1, 1'b0);
    step1(16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1);

    // Constant 100 frame then flush
    do_reset();
    const_frame(F, 16'd100);
    const_frame(D, 16'd0);
    step(1'b0, '0, '0);

    // Ramp, continuous
    do_reset();
    for (int n = 0; n < F; n++) step(1'b1, 16'(n), 16'(-n));
    const_frame(D, 16'd0);

    // Ramp with alternating then random gaps
    do_reset();
    for (int n = 0; n < F + D; n++) begin
      r = (n < F) ? 16'(n) : 16'h0;
      q = (n < F) ? 16'(-n) : 16'h0;
      step(1'b1, r, q);
      if (n < 16) step(1'b0, '0, '0);
      else repeat ($urandom_range(0, 3)) step(1'b0, '0, '0);
    end

    // Random data across several frames, random gaps, full-scale values
    do_reset();
    for (int n = 0; n < 3 * F + D; n++) begin
      r = 16'($urandom);
      q = 16'($urandom);
      if (n % 7 == 0) r = 16'h8000;
      if (n % 11 == 0) q = 16'h7FFF;
      step(1'b1, r, q);
      repeat ($urandom_range(0, 2)) step(1'b0, '0, '0);
    end

    // Reset mid-frame after 40 accepts, then a clean frame
    do_reset();
    const_frame(40, 16'd100);
    do_reset();
    const_frame(F, 16'd100);
    const_frame(D, 16'd0);

    // Back-to-back frames A=5 and B=1
    do_reset();
    const_frame(F, 16'd5);
    const_frame(F, 16'd1);
    const_frame(D, 16'd0);
    step(1'b0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
